serial_frame_receiver: RTL and testbench

//  Downstream consumer of the ripple clock-divider outputs. Samples one divided clock
//  (e.g. Clock_8) as a data signal and turns its rising edges into single-cycle sample strobes.

---
 rtl/serial_frame_receiver_if.sv | 24 ++
 rtl/serial_frame_receiver.sv | 229 ++++++++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_receiver_if.sv
// Receiver-to-datapath interface: valid/ready data holding register plus status pulses.
//   master : receiver side (drives Data, DataValid, FrameError, Overrun, ParityError, Busy)
//   slave  : consumer side (drives DataReady)
interface serial_frame_receiver_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  DataReady;
  logic [DATA_WIDTH-1:0] Data;
  logic                  DataValid;
  logic                  FrameError;
  logic                  Overrun;
  logic                  ParityError;
  logic                  Busy;

  modport master (
    input  DataReady,
    output Data, DataValid, FrameError, Overrun, ParityError, Busy
  );

  modport slave (
    output DataReady,
    input  Data, DataValid, FrameError, Overrun, ParityError, Busy
  );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver: UART-style deframer clocked by strobes derived from a divided clock.
// SampleClock is synchronised and edge-detected into 1-cycle strobes; SerialIn is oversampled
// on those strobes and deframed LSB first (start 0, DATA_WIDTH data bits, stop 1).
// Optional feature macro: RX_PARITY_EN adds an even-parity bit between data and stop.
// Ports:
//   Clock, Reset       system clock, asynchronous active-high reset
//   SampleClock        divided clock, treated as data
//   SerialIn           serial line, idles high
//   rx (master)        DataReady in; Data/DataValid holding register, FrameError/Overrun/
//                      ParityError 1-cycle pulses, Busy
module serial_frame_receiver #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned OVERSAMPLE  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    SampleClock,
  input  logic                    SerialIn,
  serial_frame_receiver_if.master rx
);

  localparam int unsigned CntW = $clog2(OVERSAMPLE + 1);
  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntW-1:0] CntHalf = CntW'(OVERSAMPLE / 2);
  localparam logic [CntW-1:0] CntFull = CntW'(OVERSAMPLE);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_WIDTH - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StStop   = 3'd4;
`ifdef RX_PARITY_EN
  localparam logic [2:0] StParity = 3'd3;
`endif

  logic [SYNC_STAGES-1:0] samp_sync_q, ser_sync_q;
  logic                   samp_prev_q, strobe_q;
  logic                   s;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      samp_sync_q <= '0;
      ser_sync_q  <= '1;
      samp_prev_q <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      samp_sync_q <= {samp_sync_q[SYNC_STAGES-2:0], SampleClock};
      ser_sync_q  <= {ser_sync_q[SYNC_STAGES-2:0], SerialIn};
      samp_prev_q <= samp_sync_q[SYNC_STAGES-1];
      strobe_q    <= samp_sync_q[SYNC_STAGES-1] & ~samp_prev_q;
    end
  end

  assign s = ser_sync_q[SYNC_STAGES-1];

  logic [2:0]            state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  prev_q, prev_d;
  // Cleared by reset and set by the first strobe, so a line already low when reset
  // releases (prev still at its reset value) cannot be mistaken for a falling edge.
  logic                  armed_q, armed_d;
  logic                  done_ok, fe_d, fe_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, ov_q, ov_d, accept;
`ifdef RX_PARITY_EN
  logic                  par_bad_q, par_bad_d, pe_q, pe_d;
`endif

  assign cnt_inc = cnt_q + 1'b1;
  assign accept  = valid_q & rx.DataReady;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    prev_d  = prev_q;
    armed_d = armed_q;
    done_ok = 1'b0;
    fe_d    = 1'b0;
`ifdef RX_PARITY_EN
    par_bad_d = par_bad_q;
    pe_d      = 1'b0;
`endif
    if (strobe_q) begin
      prev_d  = s;
      armed_d = 1'b1;
      case (state_q)
        StIdle: begin
          if (armed_q && prev_q && !s) begin
            state_d = StStart;
            cnt_d   = CntW'(1);
          end
        end
        StStart: begin
          // Compared before incrementing so the decision lands mid start bit; a low
          // pulse shorter than that returns to idle as a glitch.
          if (cnt_q == CntHalf) begin
            if (!s) begin
              state_d = StData;
              cnt_d   = '0;
              bit_d   = '0;
`ifdef RX_PARITY_EN
              par_bad_d = 1'b0;
`endif
            end else begin
              state_d = StIdle;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StData: begin
          if (cnt_inc == CntFull) begin
            cnt_d          = '0;
            shift_d[bit_q] = s;
            if (bit_q == LastBit) begin
`ifdef RX_PARITY_EN
              state_d = StParity;
`else
              state_d = StStop;
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
`ifdef RX_PARITY_EN
        StParity: begin
          if (cnt_inc == CntFull) begin
            cnt_d     = '0;
            par_bad_d = (^shift_q) ^ s;
            state_d   = StStop;
          end else begin
            cnt_d = cnt_inc;
          end
        end
`endif
        StStop: begin
          if (cnt_inc == CntFull) begin
            cnt_d   = '0;
            state_d = StIdle;
            if (!s) begin
              fe_d = 1'b1;
`ifdef RX_PARITY_EN
            end else if (par_bad_q) begin
              pe_d = 1'b1;
`endif
            end else begin
              done_ok = 1'b1;
            end
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Holding register: an accept in the load cycle frees the slot for the new word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ov_d    = 1'b0;
    if (accept) valid_d = 1'b0;
    if (done_ok) begin
      if (!valid_q || accept) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      prev_q  <= 1'b1;
      armed_q <= 1'b0;
      fe_q    <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      fe_q    <= fe_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ov_q    <= ov_d;
    end
  end

`ifdef RX_PARITY_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      par_bad_q <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      pe_q      <= pe_d;
    end
  end
  assign rx.ParityError = pe_q;
`else
  assign rx.ParityError = 1'b0;
`endif

  assign rx.Data       = data_q;
  assign rx.DataValid  = valid_q;
  assign rx.FrameError = fe_q;
  assign rx.Overrun    = ov_q;
  assign rx.Busy       = (state_q != StIdle);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: DATA_WIDTH=8, OVERSAMPLE=4, SampleClock=Clock/8.
module tb_serial_frame_receiver;

  logic Clock = 1'b0;
  logic Reset, SampleClock, SerialIn;
  always #5 Clock = ~Clock;

  serial_frame_receiver_if #(.DATA_WIDTH(8)) rx_if ();

  serial_frame_receiver #(
    .DATA_WIDTH (8),
    .OVERSAMPLE (4),
    .SYNC_STAGES(2)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .SampleClock(SampleClock),
    .SerialIn   (SerialIn),
    .rx         (rx_if)
  );

  int checks = 0;
  int failures = 0;

  // Cumulative event counters sampled away from the active edge.
  int valid_cyc = 0, valid_rise = 0, fe_cyc = 0, ov_cyc = 0, pe_cyc = 0, busy_cyc = 0;
  logic valid_prev = 1'b0;
  logic [7:0] last_data = 8'h00;

  always @(negedge Clock) begin
    if (rx_if.DataValid) begin
      valid_cyc = valid_cyc + 1;
      last_data = rx_if.Data;
    end
    if (rx_if.DataValid && !valid_prev) valid_rise = valid_rise + 1;
    valid_prev = rx_if.DataValid;
    if (rx_if.FrameError)  fe_cyc = fe_cyc + 1;
    if (rx_if.Overrun)     ov_cyc = ov_cyc + 1;
    if (rx_if.ParityError) pe_cyc = pe_cyc + 1;
    if (rx_if.Busy)        busy_cyc = busy_cyc + 1;
  end

`ifdef RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  // One SampleClock period (8 Clocks) with the line held at v; starts and ends on a negedge.
  task automatic strobe_period(input logic v);
    SerialIn    = v;
    SampleClock = 1'b1;
    repeat (4) @(negedge Clock);
    SampleClock = 1'b0;
    repeat (4) @(negedge Clock);
  endtask

  task automatic send_bit(input logic v);
    repeat (4) strobe_period(v);
  endtask

  task automatic idle(input int n);
    repeat (n) strobe_period(1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef RX_PARITY_EN
    send_bit((^b) ^ par_flip);
`endif
    send_bit(stop);
  endtask

  task automatic test_reset();
    int b0;
    Reset = 1'b1; SampleClock = 1'b0; SerialIn = 1'b0; rx_if.DataReady = 1'b0;
    repeat (3) @(negedge Clock);
    checks++; if (rx_if.Data !== 8'h00) begin failures++;
      $display("FAIL reset_data got=%h exp=00", rx_if.Data); end
    checks++; if (rx_if.DataValid !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", rx_if.DataValid); end
    checks++; if (rx_if.Busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", rx_if.Busy); end
    checks++;
    if ({rx_if.FrameError, rx_if.Overrun, rx_if.ParityError} !== 3'b000) begin failures++;
      $display("FAIL reset_pulses got=%b exp=000",
               {rx_if.FrameError, rx_if.Overrun, rx_if.ParityError}); end
    Reset = 1'b0;
    b0 = busy_cyc;
    repeat (6) strobe_period(1'b0);
    checks++; if (busy_cyc - b0 !== 0) begin failures++;
      $display("FAIL low_since_reset busy_cycles got=%0d exp=0", busy_cyc - b0); end
    idle(4);
  endtask

  task automatic test_single();
    int r0, c0, e0;
    rx_if.DataReady = 1'b1;
    r0 = valid_rise; c0 = valid_cyc; e0 = fe_cyc + ov_cyc + pe_cyc;
    send_frame(8'hA5, 1'b1);
    idle(2);
    checks++; if (last_data !== 8'hA5) begin failures++;
      $display("FAIL single_data got=%h exp=a5", last_data); end
    checks++; if (valid_cyc - c0 !== 1) begin failures++;
      $display("FAIL single_valid_cycles got=%0d exp=1", valid_cyc - c0); end
    checks++; if (valid_rise - r0 !== 1) begin failures++;
      $display("FAIL single_valid_rises got=%0d exp=1", valid_rise - r0); end
    checks++; if (fe_cyc + ov_cyc + pe_cyc - e0 !== 0) begin failures++;
      $display("FAIL single_err_pulses got=%0d exp=0", fe_cyc + ov_cyc + pe_cyc - e0); end
    checks++; if (rx_if.Data !== 8'hA5 || rx_if.DataValid !== 1'b0) begin failures++;
      $display("FAIL single_hold got=%h/%b exp=a5/0", rx_if.Data, rx_if.DataValid); end
  endtask

  task automatic test_overrun();
    int o0;
    rx_if.DataReady = 1'b0;
    send_frame(8'h3C, 1'b1);
    idle(2);
    checks++; if (rx_if.Data !== 8'h3C || rx_if.DataValid !== 1'b1) begin failures++;
      $display("FAIL ovr_first got=%h/%b exp=3c/1", rx_if.Data, rx_if.DataValid); end
    o0 = ov_cyc;
    send_frame(8'h81, 1'b1);
    idle(2);
    checks++; if (ov_cyc - o0 !== 1) begin failures++;
      $display("FAIL ovr_pulses got=%0d exp=1", ov_cyc - o0); end
    checks++; if (rx_if.Data !== 8'h3C || rx_if.DataValid !== 1'b1) begin failures++;
      $display("FAIL ovr_retain got=%h/%b exp=3c/1", rx_if.Data, rx_if.DataValid); end
    rx_if.DataReady = 1'b1;
    @(negedge Clock);
    checks++; if (rx_if.DataValid !== 1'b0) begin failures++;
      $display("FAIL ovr_accept valid got=%b exp=0", rx_if.DataValid); end
  endtask

  task automatic test_frame_error();
    int f0, r0, fc;
    rx_if.DataReady = 1'b1;
    f0 = fe_cyc; r0 = valid_rise;
    send_frame(8'h55, 1'b0);
    idle(2);
    fc = fe_cyc - f0;
    checks++; if (fc !== 1) begin failures++;
      $display("FAIL fe_pulse_cycles got=%0d exp=1", fc); end
    checks++; if (valid_rise - r0 !== 0) begin failures++;
      $display("FAIL fe_valid_rises got=%0d exp=0", valid_rise - r0); end
    checks++; if (rx_if.Busy !== 1'b0) begin failures++;
      $display("FAIL fe_busy got=%b exp=0", rx_if.Busy); end
    r0 = valid_rise;
    send_frame(8'h12, 1'b1);
    idle(2);
    checks++; if (last_data !== 8'h12 || valid_rise - r0 !== 1) begin failures++;
      $display("FAIL fe_recover got=%h/%0d exp=12/1", last_data, valid_rise - r0); end
  endtask

  task automatic test_glitch();
    int b0, r0, e0;
    idle(2);
    b0 = busy_cyc; r0 = valid_rise; e0 = fe_cyc + ov_cyc + pe_cyc;
    strobe_period(1'b0);
    strobe_period(1'b0);
    strobe_period(1'b1);
    checks++; if (rx_if.Busy !== 1'b0) begin failures++;
      $display("FAIL glitch_busy_after3 got=%b exp=0", rx_if.Busy); end
    checks++; if (busy_cyc - b0 == 0) begin failures++;
      $display("FAIL glitch_start_seen busy_cycles got=0 exp=nonzero"); end
    idle(8);
    checks++; if (valid_rise - r0 !== 0 || fe_cyc + ov_cyc + pe_cyc - e0 !== 0) begin
      failures++;
      $display("FAIL glitch_quiet rises=%0d pulses=%0d exp=0/0", valid_rise - r0,
               fe_cyc + ov_cyc + pe_cyc - e0); end
  endtask

  task automatic test_midframe_reset();
    rx_if.DataReady = 1'b1;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    strobe_period(1'b1);
    strobe_period(1'b1);
    checks++; if (rx_if.Busy !== 1'b1) begin failures++;
      $display("FAIL mid_busy_before got=%b exp=1", rx_if.Busy); end
    Reset = 1'b1;
    #1;
    checks++; if (rx_if.Data !== 8'h00 || rx_if.DataValid !== 1'b0 || rx_if.Busy !== 1'b0)
    begin failures++;
      $display("FAIL mid_reset got=%h/%b/%b exp=00/0/0", rx_if.Data, rx_if.DataValid,
               rx_if.Busy); end
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    idle(4);
    rx_if.DataReady = 1'b0;
    send_frame(8'h0F, 1'b1);
    idle(2);
    checks++; if (rx_if.Data !== 8'h0F || rx_if.DataValid !== 1'b1) begin failures++;
      $display("FAIL mid_after got=%h/%b exp=0f/1", rx_if.Data, rx_if.DataValid); end
    rx_if.DataReady = 1'b1;
    @(negedge Clock);
  endtask

`ifdef RX_PARITY_EN
  task automatic test_parity();
    int p0, r0;
    rx_if.DataReady = 1'b1;
    par_flip = 1'b0;
    r0 = valid_rise;
    send_frame(8'h07, 1'b1);
    idle(2);
    checks++; if (last_data !== 8'h07 || valid_rise - r0 !== 1) begin failures++;
      $display("FAIL par_good got=%h/%0d exp=07/1", last_data, valid_rise - r0); end
    par_flip = 1'b1;
    p0 = pe_cyc; r0 = valid_rise;
    send_frame(8'h07, 1'b1);
    idle(2);
    par_flip = 1'b0;
    checks++; if (pe_cyc - p0 !== 1 || valid_rise - r0 !== 0) begin failures++;
      $display("FAIL par_bad pe=%0d rises=%0d exp=1/0", pe_cyc - p0, valid_rise - r0); end
  endtask
`endif

  initial begin
    @(negedge Clock);
    test_reset();
    test_single();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_midframe_reset();
`ifdef RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
